// File: rtl/tile_scheduler_if.sv
// ---------------------------------------------------------------------------
// tile_scheduler_if
//   Descriptor handshake between the tile scheduler and the 2x2 systolic core
//   FSM.
//
//   Signals:
//     tile_valid      scheduler -> core  descriptor valid
//     tile_ready      core -> scheduler  descriptor accepted
//     tile_*_off      scheduler -> core  tile origin (DIM_W bits)
//     tile_*_len      scheduler -> core  tile extent, clipped at matrix edges
//     tile_first_k    scheduler -> core  first k-tile: clear accumulators
//     tile_last_k     scheduler -> core  last k-tile: write back results
//     core_tile_done  core -> scheduler  single-cycle tile completion pulse
//
//   Modports: master = scheduler side, slave = core side.
// ---------------------------------------------------------------------------
interface tile_scheduler_if #(
  parameter int unsigned DIM_W = 32
);
  logic             tile_valid;
  logic             tile_ready;
  logic [DIM_W-1:0] tile_m_off;
  logic [DIM_W-1:0] tile_n_off;
  logic [DIM_W-1:0] tile_k_off;
  logic [DIM_W-1:0] tile_m_len;
  logic [DIM_W-1:0] tile_n_len;
  logic [DIM_W-1:0] tile_k_len;
  logic             tile_first_k;
  logic             tile_last_k;
  logic             core_tile_done;

  modport master (
    output tile_valid,
    output tile_m_off, tile_n_off, tile_k_off,
    output tile_m_len, tile_n_len, tile_k_len,
    output tile_first_k, tile_last_k,
    input  tile_ready,
    input  core_tile_done
  );

  modport slave (
    input  tile_valid,
    input  tile_m_off, tile_n_off, tile_k_off,
    input  tile_m_len, tile_n_len, tile_k_len,
    input  tile_first_k, tile_last_k,
    output tile_ready,
    output core_tile_done
  );
endinterface

// File: rtl/tile_scheduler.sv
// ---------------------------------------------------------------------------
// tile_scheduler
//   Walks a full M x N x K GEMM in Tm x Tn x Tk tiles (k innermost, then n,
//   then m) and hands one tile descriptor at a time to the systolic core.
//   Dimensions and tile sizes are captured on start_pulse. Read-bank selects
//   ping-pong after every completed tile; per-tile and end-of-job pulses are
//   returned to the CSR block.
//
//   Parameters:
//     DIM_W      width of dimension, tile-size and offset values
//     PING_PONG  1: toggle bank selects per completed tile, 0: hold at 0
//
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     start_pulse, abort_pulse    single-cycle job start / abort from CSR
//     cfg_M/N/K, cfg_Tm/Tn/Tk     problem dimensions and tile sizes
//     tile_if (master)            descriptor handshake to the core
//     busy                        job in progress
//     done_tile_pulse             one cycle per completed tile
//     job_done_pulse              one cycle when the last tile completes
//     cfg_err_pulse               start rejected, a cfg value was zero
//     bank_sel_rd_A/B             read-bank selects mirrored to CSR
//
//   Optional feature (macro TILE_SCHED_PERF_EN):
//     perf_tiles_issued           accepted descriptors, saturating
//     perf_stall_cycles           ISSUE cycles with tile_ready low, saturating
// ---------------------------------------------------------------------------
module tile_scheduler #(
  parameter int unsigned DIM_W     = 32,
  parameter bit          PING_PONG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_pulse,
  input  logic             abort_pulse,
  input  logic [DIM_W-1:0] cfg_M,
  input  logic [DIM_W-1:0] cfg_N,
  input  logic [DIM_W-1:0] cfg_K,
  input  logic [DIM_W-1:0] cfg_Tm,
  input  logic [DIM_W-1:0] cfg_Tn,
  input  logic [DIM_W-1:0] cfg_Tk,
  tile_scheduler_if.master tile_if,
  output logic             busy,
  output logic             done_tile_pulse,
  output logic             job_done_pulse,
  output logic             cfg_err_pulse,
  output logic             bank_sel_rd_A,
  output logic             bank_sel_rd_B
`ifdef TILE_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_tiles_issued,
  output logic [31:0]      perf_stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ADVANCE,
    S_FINISH
  } state_t;

  state_t state;

  logic [DIM_W-1:0] dim_m, dim_n, dim_k;
  logic [DIM_W-1:0] t_m, t_n, t_k;
  logic [DIM_W-1:0] m_off, n_off, k_off;
  logic [DIM_W-1:0] m_len, n_len, k_len;
  logic             first_k, last_k;
  logic             tile_valid_q;

  logic [DIM_W-1:0] nxt_m, nxt_n, nxt_k;
  logic             k_wrap, n_wrap, m_wrap, job_end;
  logic             cfg_zero;
  logic             start_ok;

  // off + t >= dim, evaluated one bit wider so the sum never wraps.
  function automatic logic reaches_end(input logic [DIM_W-1:0] off,
                                       input logic [DIM_W-1:0] t,
                                       input logic [DIM_W-1:0] dim);
    logic [DIM_W:0] sum;
    sum = {1'b0, off} + {1'b0, t};
    return sum >= {1'b0, dim};
  endfunction

  // min(t, dim - off); off is always below dim while a tile is live.
  function automatic logic [DIM_W-1:0] clip_len(input logic [DIM_W-1:0] t,
                                                input logic [DIM_W-1:0] off,
                                                input logic [DIM_W-1:0] dim);
    logic [DIM_W-1:0] rem;
    rem = dim - off;
    return (t < rem) ? t : rem;
  endfunction

  always_comb begin
    cfg_zero = (cfg_M == '0) || (cfg_N == '0) || (cfg_K == '0) ||
               (cfg_Tm == '0) || (cfg_Tn == '0) || (cfg_Tk == '0);
    start_ok = (state == S_IDLE) && start_pulse && !abort_pulse && !cfg_zero;
  end

  // Next tile origin: k steps first, a k rollover steps n, an n rollover
  // steps m; an m rollover on top of both means the job is complete.
  always_comb begin
    k_wrap  = reaches_end(k_off, t_k, dim_k);
    n_wrap  = reaches_end(n_off, t_n, dim_n);
    m_wrap  = reaches_end(m_off, t_m, dim_m);
    nxt_k   = k_wrap ? '0 : k_off + t_k;
    nxt_n   = n_off;
    nxt_m   = m_off;
    if (k_wrap) begin
      nxt_n = n_wrap ? '0 : n_off + t_n;
      if (n_wrap) begin
        nxt_m = m_off + t_m;
      end
    end
    job_end = k_wrap && n_wrap && m_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      dim_m           <= '0;
      dim_n           <= '0;
      dim_k           <= '0;
      t_m             <= '0;
      t_n             <= '0;
      t_k             <= '0;
      m_off           <= '0;
      n_off           <= '0;
      k_off           <= '0;
      m_len           <= '0;
      n_len           <= '0;
      k_len           <= '0;
      first_k         <= 1'b0;
      last_k          <= 1'b0;
      tile_valid_q    <= 1'b0;
      busy            <= 1'b0;
      done_tile_pulse <= 1'b0;
      job_done_pulse  <= 1'b0;
      cfg_err_pulse   <= 1'b0;
      bank_sel_rd_A   <= 1'b0;
      bank_sel_rd_B   <= 1'b0;
    end else begin
      done_tile_pulse <= 1'b0;
      job_done_pulse  <= 1'b0;
      cfg_err_pulse   <= 1'b0;

      if (abort_pulse && (state != S_IDLE)) begin
        // Abort drops the job without any completion pulse; bank selects
        // and descriptor fields keep their current values.
        state        <= S_IDLE;
        tile_valid_q <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_pulse && !abort_pulse) begin
              dim_m <= cfg_M;
              dim_n <= cfg_N;
              dim_k <= cfg_K;
              t_m   <= cfg_Tm;
              t_n   <= cfg_Tn;
              t_k   <= cfg_Tk;
              if (cfg_zero) begin
                cfg_err_pulse <= 1'b1;
              end else begin
                m_off         <= '0;
                n_off         <= '0;
                k_off         <= '0;
                m_len         <= clip_len(cfg_Tm, '0, cfg_M);
                n_len         <= clip_len(cfg_Tn, '0, cfg_N);
                k_len         <= clip_len(cfg_Tk, '0, cfg_K);
                first_k       <= 1'b1;
                last_k        <= reaches_end('0, cfg_Tk, cfg_K);
                bank_sel_rd_A <= 1'b0;
                bank_sel_rd_B <= 1'b0;
                busy          <= 1'b1;
                tile_valid_q  <= 1'b1;
                state         <= S_ISSUE;
              end
            end
          end

          S_ISSUE: begin
            if (tile_if.tile_ready) begin
              tile_valid_q <= 1'b0;
              state        <= S_WAIT;
            end
          end

          S_WAIT: begin
            if (tile_if.core_tile_done) begin
              done_tile_pulse <= 1'b1;
              if (PING_PONG) begin
                bank_sel_rd_A <= !bank_sel_rd_A;
                bank_sel_rd_B <= !bank_sel_rd_B;
              end
              state <= S_ADVANCE;
            end
          end

          S_ADVANCE: begin
            if (job_end) begin
              // Offsets are left untouched so the last descriptor stays
              // visible while idle.
              job_done_pulse <= 1'b1;
              state          <= S_FINISH;
            end else begin
              m_off        <= nxt_m;
              n_off        <= nxt_n;
              k_off        <= nxt_k;
              m_len        <= clip_len(t_m, nxt_m, dim_m);
              n_len        <= clip_len(t_n, nxt_n, dim_n);
              k_len        <= clip_len(t_k, nxt_k, dim_k);
              first_k      <= (nxt_k == '0);
              last_k       <= reaches_end(nxt_k, t_k, dim_k);
              tile_valid_q <= 1'b1;
              state        <= S_ISSUE;
            end
          end

          S_FINISH: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tile_if.tile_valid   = tile_valid_q;
  assign tile_if.tile_m_off   = m_off;
  assign tile_if.tile_n_off   = n_off;
  assign tile_if.tile_k_off   = k_off;
  assign tile_if.tile_m_len   = m_len;
  assign tile_if.tile_n_len   = n_len;
  assign tile_if.tile_k_len   = k_len;
  assign tile_if.tile_first_k = first_k;
  assign tile_if.tile_last_k  = last_k;

`ifdef TILE_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_tiles_issued <= '0;
      perf_stall_cycles <= '0;
    end else if (start_ok) begin
      perf_tiles_issued <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (tile_valid_q && tile_if.tile_ready && (perf_tiles_issued != '1)) begin
        perf_tiles_issued <= perf_tiles_issued + 32'd1;
      end
      if ((state == S_ISSUE) && !tile_if.tile_ready && (perf_stall_cycles != '1)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`else
  // start_ok only feeds the performance counters.
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
Sequences the 2×2 systolic core over a full GEMM of M×N×K, split into Tm×Tn×Tk tiles.
- Snapshots dimensions and tile sizes from the control/status block on start_pulse.
- Walks tile offsets with k innermost, then n, then m. Issues one tile descriptor per core handshake.
- Ping-pongs the read-bank selects and raises per-tile and end-of-job pulses back to the CSR block.
- Sits between the CSR block and the core FSM.

Parameters:
DIM_W, 32, width of dimension, tile-size and offset values
PING_PONG, 1, 1 = toggle bank_sel_rd_A/B after every completed tile; 0 = hold both at 0

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_pulse  in  1  single-cycle job start from CSR
abort_pulse  in  1  single-cycle abort from CSR
cfg_M, cfg_N, cfg_K  in  DIM_W  problem dimensions
cfg_Tm, cfg_Tn, cfg_Tk  in  DIM_W  tile sizes
tile_valid  out  1  descriptor valid to core
tile_ready  in  1  core accepts descriptor
tile_m_off, tile_n_off, tile_k_off  out  DIM_W  tile origin
tile_m_len, tile_n_len, tile_k_len  out  DIM_W  tile extent, clipped at edges
tile_first_k  out  1  first k-tile of an (m,n) block: clear accumulators
tile_last_k  out  1  last k-tile of an (m,n) block: write back results
core_tile_done  in  1  single-cycle pulse, core finished the issued tile
busy  out  1  job in progress
done_tile_pulse  out  1  one cycle per completed tile (feeds CSR sticky status and result capture)
job_done_pulse  out  1  one cycle when the last tile completes
cfg_err_pulse  out  1  start rejected: a dimension or tile size is zero
bank_sel_rd_A, bank_sel_rd_B  out  1  read-bank selects mirrored to CSR

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- FSM states: IDLE, ISSUE, WAIT, ADVANCE, FINISH.
- IDLE:
  - On start_pulse, snapshot all cfg_* inputs.
  - If any snapshotted value is 0: pulse cfg_err_pulse next cycle, stay in IDLE.
  - Otherwise: zero all offsets and bank selects, go to ISSUE. busy=1 and tile_valid=1 in the following cycle (1-cycle start latency).
- ISSUE: tile_valid held high with stable descriptor fields until tile_ready is sampled high. Then tile_valid=0 next cycle, go to WAIT.
- WAIT:
  - On core_tile_done: pulse done_tile_pulse next cycle, toggle both bank selects if PING_PONG, go to ADVANCE.
  - core_tile_done seen in any other state is ignored.
- ADVANCE (one cycle), advance offsets in this order:
  - k_off += Tk.
  - If k_off + Tk ≥ K: k_off = 0, n_off += Tn.
  - If n_off rolls over likewise: n_off = 0, m_off += Tm.
  - If m_off rolls over too: go to FINISH; otherwise go to ISSUE.
- Overflow rule: all "off + T ≥ dim" comparisons are DIM_W+1 bits wide, so no overflow when an offset plus a tile size exceeds 2^DIM_W−1.
- Edge clipping: len = min(T, dim − off). Example: M=5, Tm=2 gives m tiles of length 2, 2, 1.
- tile_first_k = (k_off==0). tile_last_k = (k_off + Tk ≥ K). Both valid while tile_valid is high.
- FINISH: job_done_pulse=1 for one cycle, busy=0, return to IDLE.
- start_pulse while busy: ignored (CSR already guards this; no state change here).
- abort_pulse in any non-IDLE state: next cycle go to IDLE.
  - tile_valid=0, busy=0; no done_tile_pulse or job_done_pulse.
  - Bank selects keep their current values.
- abort_pulse and start_pulse in the same cycle: abort wins, job does not start.
- abort_pulse and core_tile_done in the same cycle: abort wins.
- Reset mid-job: immediate return to reset values.
- Descriptor outputs hold their last values while idle.

Optional Feature:
TILE_SCHED_PERF_EN
- Defined: adds outputs perf_tiles_issued (32b, increments on each tile_valid&&tile_ready) and perf_stall_cycles (32b, increments each cycle in ISSUE with tile_ready=0). Both clear on an accepted start, saturate at 0xFFFF_FFFF, and hold after job end or abort.
- Undefined: neither port nor counter exists.

Test Plan:
- M=N=K=4, Tm=Tn=Tk=2, core handshakes immediately:
  - Expect 8 descriptors in (m,n,k) order (0,0,0),(0,0,2),(0,2,0),…,(2,2,2).
  - first_k/last_k alternate 1/0 and 0/1.
  - 8 done_tile_pulse, then exactly 1 job_done_pulse; bank selects end at 0.
- M=5, N=3, K=3, Tm=2, Tn=2, Tk=2:
  - m_len sequence 2,2,1; n_len 2,1; k_len 2,1.
  - 12 tiles total; busy drops one cycle after the final job_done_pulse.
- start with Tk=0 → cfg_err_pulse=1 for 1 cycle; busy stays 0; no tile_valid.
- tile_ready held low for 5 cycles on first tile → descriptor stable throughout, then accepted; with TILE_SCHED_PERF_EN, perf_stall_cycles=5.
- abort_pulse during WAIT of the 3rd tile of a 4×4×4/2 job → next cycle busy=0, tile_valid=0; no job_done_pulse; a later core_tile_done is ignored.
- M=0xFFFF_FFFF, Tm=0x8000_0000, N=K=Tn=Tk=1 → 2 tiles with m_off 0 and 0x8000_0000, m_len 0x8000_0000 and 0x7FFF_FFFF; no wrap to a third tile.
